// File: rtl/dataframe_send.sv
// Downlink frame replay buffer: stores user-data words and plays them back one per clk40 frame.
// Optional continuous replay is enabled by defining DATAFRAME_SEND_LOOP_EN (adds loop_i).
module dataframe_send #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk40_i,
  input  logic              RST,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              clear_i,
`ifdef DATAFRAME_SEND_LOOP_EN
  input  logic              loop_i,
`endif
  input  logic [DATA_W-1:0] idle_pattern_i,
  input  logic              downlinkrdy_i,
  output logic [DATA_W-1:0] downlinkUserData_o,
  output logic              downlink_valid_o,
  output logic [ADDR_W:0]   level_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              rdy_lost_o
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              rdy_lost_q, rdy_lost_d;
  logic              loop_q, loop_d;
  logic              valid_q, done_q, done_d;
  logic [DATA_W-1:0] idle_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_en, rd_en, last_word, loop_start;
  logic [ADDR_W:0]   last_idx;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef DATAFRAME_SEND_LOOP_EN
  assign loop_start = loop_i;
`else
  assign loop_start = 1'b0;
`endif

  assign wr_ready_o = (state_q == ST_IDLE) && (count_q < DEPTH_C);
  assign last_idx   = count_q - (ADDR_W + 1)'(1);
  assign last_word  = ({1'b0, rd_ptr_q} == last_idx);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    rdy_lost_d = rdy_lost_q;
    loop_d     = loop_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // clear has priority over a same-cycle write
        if (clear_i) begin
          count_d = '0;
        end else if (wr_valid_i && wr_ready_o) begin
          wr_en   = 1'b1;
          count_d = count_q + (ADDR_W + 1)'(1);
        end
        if (start_i && !stop_i) begin
          rdy_lost_d = 1'b0;
          if (count_d != '0) begin
            state_d = ST_ARMED;
            loop_d  = loop_start;
          end
        end
      end
      ST_ARMED: begin
        rd_ptr_d = '0;
        if (stop_i)             state_d = ST_IDLE;
        else if (downlinkrdy_i) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (downlinkrdy_i) begin
          rd_en = 1'b1;
          if (last_word) begin
            rd_ptr_d = '0;
            if (!loop_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end else begin
          rdy_lost_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk40_i or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      rdy_lost_q <= 1'b0;
      loop_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      rdy_lost_q <= rdy_lost_d;
      loop_q     <= loop_d;
      valid_q    <= rd_en;
      done_q     <= done_d;
      idle_q     <= idle_pattern_i;
    end
  end

  // Storage kept free of reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge clk40_i) begin
    if (wr_en) mem[count_q[ADDR_W-1:0]] <= wr_data_i;
    rd_data_q <= mem[rd_ptr_q];
  end

  assign downlinkUserData_o = valid_q ? rd_data_q : idle_q;
  assign downlink_valid_o   = valid_q;
  assign done_o             = done_q;
  assign level_o            = count_q;
  assign busy_o             = (state_q != ST_IDLE);
  assign rdy_lost_o         = rdy_lost_q;

endmodule
